// File: rtl/sn74_tester_pkg.sv
// Shared types, constants and helpers for the sn74-series gate testers.
package sn74_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } testerState_e;

  localparam int NUM_PATTERNS       = 16;
  localparam int CHECKS_PER_PATTERN = 2;
  localparam logic [3:0] LAST_PAT   = 4'(NUM_PATTERNS - 1);

  // Ideal response of one 4-input NAND gate.
  function automatic logic nand4(input logic [3:0] x);
    return ~&x;
  endfunction

endpackage

// File: rtl/sn74_settle_timer.sv
// Loadable down-counter; expire_o pulses for one cycle in the last cycle
// of a loaded count (load N, pulse N cycles after the load edge).
module sn74_settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/sn74_nand4_tester.sv
// Exhaustive tester for a dual 4-input NAND (sn7413-class): gate A walks 0..15, gate B its complement.
// Define SN74_NAND4_TESTER_STOP_ON_FAIL_EN to end a run at the first failing check.
module sn74_nand4_tester
  import sn74_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [3:0]       a_in,
  output logic [3:0]       b_in,
  input  logic             a_y,
  input  logic             b_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] error_count,
  output logic             fail_a,
  output logic             fail_b,
  output logic [3:0]       first_fail_pat
);

  testerState_e     state_q, state_d;
  logic [3:0]       pat_q, pat_d;
  logic [CNT_W-1:0] testCount_q, testCount_d;
  logic [CNT_W-1:0] errCount_q, errCount_d;
  logic             failA_q, failA_d, failB_q, failB_d;
  logic             pass_q, pass_d;
  logic [3:0]       firstFail_q, firstFail_d;
  logic             settleDone, loadTimer;
  logic             mismA, mismB, endRun;
  logic [1:0]       mismCount;

  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                              input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Timer is reloaded on every entry into DRIVE, so it expires in the last settle cycle.
  assign loadTimer = (state_d == ST_DRIVE) && (state_q != ST_DRIVE);

  sn74_settle_timer #(
    .WIDTH(4)
  ) u_settleTimer (
    .clk         (clk),
    .reset       (reset),
    .load_i      (loadTimer),
    .load_value_i(4'(SETTLE_CYCLES)),
    .expire_o    (settleDone)
  );

  // Case inequality so that an undriven or unknown gate output reads as a failure.
  assign mismA     = (a_y !== nand4(pat_q));
  assign mismB     = (b_y !== nand4(~pat_q));
  assign mismCount = {1'b0, mismA} + {1'b0, mismB};

`ifdef SN74_NAND4_TESTER_STOP_ON_FAIL_EN
  assign endRun = (pat_q == LAST_PAT) || mismA || mismB;
`else
  assign endRun = (pat_q == LAST_PAT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_DRIVE;
      ST_DRIVE: if (settleDone) state_d = ST_CHECK;
      ST_CHECK: state_d = endRun ? ST_DONE : ST_DRIVE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_in = '0;
    b_in = '0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_DRIVE, ST_CHECK: begin
        a_in = pat_q;
        b_in = ~pat_q;
        busy = 1'b1;
      end
      ST_DONE: begin
        a_in = pat_q;
        b_in = ~pat_q;
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Results are latched at the CHECK->DONE edge so pass is valid alongside the done pulse.
  always_comb begin
    pat_d       = pat_q;
    testCount_d = testCount_q;
    errCount_d  = errCount_q;
    failA_d     = failA_q;
    failB_d     = failB_q;
    firstFail_d = firstFail_q;
    pass_d      = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d       = '0;
          testCount_d = '0;
          errCount_d  = '0;
          failA_d     = 1'b0;
          failB_d     = 1'b0;
          firstFail_d = '0;
          pass_d      = 1'b0;
        end
      end
      ST_CHECK: begin
        testCount_d = satAdd(testCount_q, 2'(CHECKS_PER_PATTERN));
        errCount_d  = satAdd(errCount_q, mismCount);
        failA_d     = failA_q | mismA;
        failB_d     = failB_q | mismB;
        if ((mismA || mismB) && !(failA_q || failB_q)) begin
          firstFail_d = pat_q;
        end
        if (endRun) begin
          pass_d = (errCount_d == '0);
        end else begin
          pat_d = pat_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q       <= '0;
      testCount_q <= '0;
      errCount_q  <= '0;
      failA_q     <= 1'b0;
      failB_q     <= 1'b0;
      firstFail_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      pat_q       <= pat_d;
      testCount_q <= testCount_d;
      errCount_q  <= errCount_d;
      failA_q     <= failA_d;
      failB_q     <= failB_d;
      firstFail_q <= firstFail_d;
      pass_q      <= pass_d;
    end
  end

  assign test_count     = testCount_q;
  assign error_count    = errCount_q;
  assign fail_a         = failA_q;
  assign fail_b         = failB_q;
  assign first_fail_pat = firstFail_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_sn74_nand4_tester.sv
// Scoreboard bench: a faulty-chip model feeds the tester; each run's result is predicted
// from the per-pattern fault masks and checked when done pulses.
module tb_sn74_nand4_tester;

  localparam int SETTLE = 1;
  localparam int CNTW   = 6;
  localparam int CNTMAX = (1 << CNTW) - 1;

  typedef struct {
    int testCount;
    int errCount;
    int failA;
    int failB;
    int firstFail;
    int pass;
    int latency;
    int startCyc;
  } expect_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [3:0]      a_in, b_in;
  logic            a_y, b_y;
  logic            busy, done, pass;
  logic [CNTW-1:0] test_count, error_count;
  logic            fail_a, fail_b;
  logic [3:0]      first_fail_pat;

  logic [15:0]     flipA, flipB;
  int              cyc = 0;
  int              nChecks = 0;
  int              nErrors = 0;
  expect_t         scoreQ[$];
  expect_t         lastExp;
  logic [28:0]     allOuts;

  sn74_nand4_tester #(
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (CNTW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .a_in          (a_in),
    .b_in          (b_in),
    .a_y           (a_y),
    .b_y           (b_y),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .test_count    (test_count),
    .error_count   (error_count),
    .fail_a        (fail_a),
    .fail_b        (fail_b),
    .first_fail_pat(first_fail_pat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chip model: ideal NAND, output inverted for input values whose mask bit is set.
  assign a_y = (~&a_in) ^ flipA[a_in];
  assign b_y = (~&b_in) ^ flipB[b_in];

  assign allOuts = {a_in, b_in, busy, done, pass, test_count, error_count,
                    fail_a, fail_b, first_fail_pat};

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Pattern p puts value p on gate A and value 15-p on gate B.
  function automatic expect_t refModel(input logic [15:0] fa, input logic [15:0] fb);
    expect_t e;
    int tests, errs, lastPat, m;
    bit found;
    tests = 0; errs = 0; lastPat = 0; found = 0;
    e.failA = 0; e.failB = 0; e.firstFail = 0; e.startCyc = 0;
    for (int p = 0; p < 16; p++) begin
      m = int'(fa[p]) + int'(fb[15 - p]);
      tests += 2;
      errs += m;
      if (fa[p]) e.failA = 1;
      if (fb[15 - p]) e.failB = 1;
      if (m > 0 && !found) begin
        found = 1;
        e.firstFail = p;
      end
      lastPat = p;
`ifdef SN74_NAND4_TESTER_STOP_ON_FAIL_EN
      if (m > 0) break;
`endif
    end
    e.testCount = (tests > CNTMAX) ? CNTMAX : tests;
    e.errCount  = (errs > CNTMAX) ? CNTMAX : errs;
    e.pass      = (errs == 0) ? 1 : 0;
    e.latency   = (lastPat + 1) * (SETTLE + 1) + 1;
    return e;
  endfunction

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (scoreQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = scoreQ.pop_front();
          checkOutput("latency", cyc - e.startCyc, e.latency);
          checkOutput("test_count", int'(test_count), e.testCount);
          checkOutput("error_count", int'(error_count), e.errCount);
          checkOutput("fail_a", int'(fail_a), e.failA);
          checkOutput("fail_b", int'(fail_b), e.failB);
          checkOutput("first_fail_pat", int'(first_fail_pat), e.firstFail);
          checkOutput("pass", int'(pass), e.pass);
          checkOutput("a_in_in_done", int'(a_in), (e.latency - 1) / (SETTLE + 1) - 1);
        end
      end
    end
  end

  task automatic waitDone(output bit seen);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checkOutput("done_timeout", 0, 1);
      scoreQ.delete();
    end
  endtask

  task automatic applyStimulus(input logic [15:0] fa, input logic [15:0] fb);
    expect_t e;
    bit seen;
    @(negedge clk);
    flipA = fa;
    flipB = fb;
    e = refModel(fa, fb);
    e.startCyc = cyc;
    scoreQ.push_back(e);
    lastExp = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_running", int'(busy), 1);
    waitDone(seen);
    @(negedge clk);
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("idle_a_in", int'(a_in), 0);
  endtask

  task automatic resetMidRun();
    @(negedge clk);
    flipA = 16'hFFFF;
    flipB = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("outputs_after_mid_reset", int'(allOuts), 0);
    repeat (40) @(negedge clk);
    checkOutput("idle_after_mid_reset", int'(busy), 0);
  endtask

  task automatic runWithRepulse();
    expect_t e;
    bit seen, busySeen;
    @(negedge clk);
    flipA = 16'h0000;
    flipB = 16'h0000;
    e = refModel(flipA, flipB);
    e.startCyc = cyc;
    scoreQ.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(seen);
    if (seen) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    busySeen = 0;
    repeat (6) begin
      if (busy) busySeen = 1;
      @(negedge clk);
    end
    checkOutput("restart_ignored", int'(busySeen), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    logic [15:0] fa, fb;
    reset = 1'b1;
    start = 1'b0;
    flipA = '0;
    flipB = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", int'(allOuts), 0);
    reset = 1'b0;

    applyStimulus(16'h0000, 16'h0000);
    applyStimulus(16'h8000, 16'h0000);
    applyStimulus(16'h0000, 16'h7FFF);
    applyStimulus(16'h7FFF, 16'h0000);

    repeat (4) @(negedge clk);
    checkOutput("hold_test_count", int'(test_count), lastExp.testCount);
    checkOutput("hold_error_count", int'(error_count), lastExp.errCount);

    resetMidRun();
    applyStimulus(16'h0000, 16'h0000);
    runWithRepulse();

    for (int i = 0; i < 20; i++) begin
      fa = 16'($urandom & $urandom & $urandom);
      fb = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) fa = '0;
      if ($urandom_range(0, 3) == 0) fb = '0;
      applyStimulus(fa, fb);
    end

    repeat (3) @(negedge clk);
    if (scoreQ.size() != 0) checkOutput("scoreboard_drained", scoreQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
